prog_seq_det: RTL and testbench

PROG_SEQ_DET -- requirements
Module: prog_seq_det

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/seq_match_cnt.sv | 22 ++
 rtl/prog_seq_det.sv | 88 ++++++++
 tb/tb_prog_seq_det.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable serial sequence detector.
package seq_det_pkg;

    typedef enum logic {
        OVERLAP     = 1'b0,
        NON_OVERLAP = 1'b1
    } det_mode_e;

    localparam logic [31:0] RST_PAT = 32'b1011;
    localparam int unsigned RST_LEN = 4;

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter; a clear on the same edge as an increment wins.
module seq_match_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_seq_det.sv
// Serial pattern detector with runtime-programmable pattern, length and overlap mode.
module prog_seq_det #(
    parameter int unsigned          MAX_LEN = 8,
    parameter int unsigned          CNT_W   = 16,
    parameter logic [MAX_LEN-1:0]   RST_PAT = MAX_LEN'(seq_det_pkg::RST_PAT),
    parameter int unsigned          RST_LEN = seq_det_pkg::RST_LEN
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         in_valid,
    input  logic                         in,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pat,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_mode,
    input  logic                         cnt_clr,
    output logic                         out,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cfg_err
);

    import seq_det_pkg::*;

    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] hist;
    logic [LW-1:0]      fill;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    det_mode_e          mode;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [LW-1:0]      fill_nxt;
    logic [MAX_LEN-1:0] mask;
    logic               cfg_ok;
    logic               match;

    always_comb begin
        hist_nxt = {hist[MAX_LEN-2:0], in};
        fill_nxt = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
        mask     = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len));
        end
        cfg_ok = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAX_LEN));
        // A config write owns the edge, so the data bit never reaches the comparator.
        match  = in_valid && !cfg_we && (fill_nxt >= len)
                 && (((hist_nxt ^ pat) & mask) == '0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hist    <= '0;
            fill    <= '0;
            pat     <= RST_PAT;
            len     <= LW'(RST_LEN);
            mode    <= OVERLAP;
            out     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            out     <= match;
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we) begin
                if (cfg_ok) begin
                    pat  <= cfg_pat;
                    len  <= cfg_len;
                    mode <= det_mode_e'(cfg_mode);
                    hist <= '0;
                    fill <= '0;
                end
            end else if (in_valid) begin
                hist <= hist_nxt;
                fill <= (match && (mode == NON_OVERLAP)) ? '0 : fill_nxt;
            end
        end
    end

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .nrst  (nrst),
        .inc   (match),
        .clr   (cnt_clr),
        .count (match_cnt)
    );

endmodule

// File: tb/tb_prog_seq_det.sv
// Directed self-checking bench for prog_seq_det (MAX_LEN = 8, CNT_W = 3).
module tb_prog_seq_det;

    logic       clk;
    logic       nrst;
    logic       in_valid;
    logic       in;
    logic       cfg_we;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_mode;
    logic       cnt_clr;
    logic       out;
    logic [2:0] match_cnt;
    logic       cfg_err;

    int total;
    int bad;

    prog_seq_det #(
        .MAX_LEN (8),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in        (in),
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_mode  (cfg_mode),
        .cnt_clr   (cnt_clr),
        .out       (out),
        .match_cnt (match_cnt),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one valid bit for one edge and samples outputs 1 time unit after it.
    task automatic send_bit(input logic b, input logic clr, output logic o, output logic [2:0] c);
        in_valid = 1'b1;
        in       = b;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
        o        = out;
        c        = match_cnt;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic idle(input int n, output logic any_out);
        any_out = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            any_out = any_out | out;
        end
    endtask

    task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic m,
                             input logic iv, output logic e, output logic o);
        cfg_we   = 1'b1;
        cfg_pat  = p;
        cfg_len  = l;
        cfg_mode = m;
        in_valid = iv;
        in       = 1'b1;
        @(posedge clk);
        #1;
        e        = cfg_err;
        o        = out;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out !== 1'b0) begin
            bad++; $display("FAIL reset_out got=%b exp=0", out);
        end
        total++;
        if (match_cnt !== 3'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt);
        end
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err);
        end
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        logic [3:0] exp;
        logic o;
        logic [2:0] c;
        bits = 4'b1011;
        exp  = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i], 1'b0, o, c);
            total++;
            if (o !== exp[i]) begin
                bad++; $display("FAIL basic_out bit%0d got=%b exp=%b", 3 - i, o, exp[i]);
            end
        end
        total++;
        if (c !== 3'd1) begin
            bad++; $display("FAIL basic_cnt got=%0d exp=1", c);
        end
        idle(1, o);
        total++;
        if (o !== 1'b0) begin
            bad++; $display("FAIL basic_pulse_width got=%b exp=0", o);
        end
    endtask

    task automatic test_overlap_modes();
        logic [6:0] bits;
        logic [6:0] exp_ov;
        logic [6:0] exp_no;
        logic o, e;
        logic [2:0] c;
        bits   = 7'b1011011;
        exp_ov = 7'b0001001;
        exp_no = 7'b0001000;
        cfg_write(8'b1011, 4'd4, 1'b0, 1'b0, e, o);
        clear_cnt();
        for (int i = 6; i >= 0; i--) begin
            send_bit(bits[i], 1'b0, o, c);
            total++;
            if (o !== exp_ov[i]) begin
                bad++; $display("FAIL overlap_out bit%0d got=%b exp=%b", 6 - i, o, exp_ov[i]);
            end
        end
        total++;
        if (c !== 3'd2) begin
            bad++; $display("FAIL overlap_cnt got=%0d exp=2", c);
        end
        // Accepted write with a coincident valid bit: bit must be dropped, count kept.
        cfg_write(8'b1011, 4'd4, 1'b1, 1'b1, e, o);
        total++;
        if (e !== 1'b0 || o !== 1'b0 || match_cnt !== 3'd2) begin
            bad++; $display("FAIL cfg_ok_write got err=%b out=%b cnt=%0d exp err=0 out=0 cnt=2", e, o, match_cnt);
        end
        for (int i = 6; i >= 0; i--) begin
            send_bit(bits[i], 1'b0, o, c);
            total++;
            if (o !== exp_no[i]) begin
                bad++; $display("FAIL nonoverlap_out bit%0d got=%b exp=%b", 6 - i, o, exp_no[i]);
            end
        end
        total++;
        if (c !== 3'd3) begin
            bad++; $display("FAIL nonoverlap_cnt got=%0d exp=3", c);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] bits;
        logic o, e, idle_o;
        logic [2:0] c;
        bits = 8'hA5;
        cfg_write(8'hA5, 4'd8, 1'b0, 1'b0, e, o);
        clear_cnt();
        for (int i = 7; i >= 0; i--) begin
            send_bit(bits[i], 1'b0, o, c);
            total++;
            if (o !== (i == 0)) begin
                bad++; $display("FAIL gap_out bit%0d got=%b exp=%b", 7 - i, o, (i == 0));
            end
            idle(2, idle_o);
            total++;
            if (idle_o !== 1'b0) begin
                bad++; $display("FAIL gap_idle_out after bit%0d got=%b exp=0", 7 - i, idle_o);
            end
        end
        total++;
        if (match_cnt !== 3'd1) begin
            bad++; $display("FAIL gap_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_cfg_err();
        logic o, e;
        logic [2:0] c;
        logic [2:0] c0;
        cfg_write(8'b1011, 4'd4, 1'b0, 1'b0, e, o);
        send_bit(1'b1, 1'b0, o, c);
        send_bit(1'b0, 1'b0, o, c0);
        cfg_write(8'hFF, 4'd1, 1'b1, 1'b1, e, o);
        total++;
        if (e !== 1'b1) begin
            bad++; $display("FAIL cfg_err_len1 got=%b exp=1", e);
        end
        idle(1, o);
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL cfg_err_width got=%b exp=0", cfg_err);
        end
        cfg_write(8'hFF, 4'd9, 1'b1, 1'b1, e, o);
        total++;
        if (e !== 1'b1) begin
            bad++; $display("FAIL cfg_err_len9 got=%b exp=1", e);
        end
        cfg_write(8'hFF, 4'd0, 1'b1, 1'b0, e, o);
        total++;
        if (e !== 1'b1) begin
            bad++; $display("FAIL cfg_err_len0 got=%b exp=1", e);
        end
        // History 1,0 survives the rejected writes; discarded bits must not extend it.
        send_bit(1'b1, 1'b0, o, c);
        total++;
        if (o !== 1'b0) begin
            bad++; $display("FAIL cfg_err_hist3 got=%b exp=0", o);
        end
        send_bit(1'b1, 1'b0, o, c);
        total++;
        if (o !== 1'b1) begin
            bad++; $display("FAIL cfg_err_hist4 got=%b exp=1", o);
        end
        total++;
        if (c !== c0 + 3'd1) begin
            bad++; $display("FAIL cfg_err_cnt got=%0d exp=%0d", c, c0 + 3'd1);
        end
    endtask

    task automatic test_saturate();
        logic o, e;
        logic [2:0] c;
        logic [3:0] bits;
        int exp_c;
        cfg_write(8'b1011, 4'd4, 1'b0, 1'b0, e, o);
        clear_cnt();
        bits = 4'b1011;
        for (int i = 3; i >= 0; i--) send_bit(bits[i], 1'b0, o, c);
        total++;
        if (o !== 1'b1 || c !== 3'd1) begin
            bad++; $display("FAIL sat_first got out=%b cnt=%0d exp out=1 cnt=1", o, c);
        end
        for (int k = 2; k <= 9; k++) begin
            send_bit(1'b0, 1'b0, o, c);
            send_bit(1'b1, 1'b0, o, c);
            send_bit(1'b1, 1'b0, o, c);
            exp_c = (k > 7) ? 7 : k;
            total++;
            if (o !== 1'b1 || c !== 3'(exp_c)) begin
                bad++; $display("FAIL sat_match%0d got out=%b cnt=%0d exp out=1 cnt=%0d", k, o, c, exp_c);
            end
        end
        send_bit(1'b0, 1'b0, o, c);
        send_bit(1'b1, 1'b0, o, c);
        send_bit(1'b1, 1'b1, o, c);
        total++;
        if (o !== 1'b1 || c !== 3'd0) begin
            bad++; $display("FAIL clr_vs_match got out=%b cnt=%0d exp out=1 cnt=0", o, c);
        end
    endtask

    task automatic test_reset_mid();
        logic o;
        logic [2:0] c;
        send_bit(1'b1, 1'b0, o, c);
        send_bit(1'b0, 1'b0, o, c);
        send_bit(1'b1, 1'b0, o, c);
        nrst = 1'b0;
        #1;
        total++;
        if (out !== 1'b0 || match_cnt !== 3'd0) begin
            bad++; $display("FAIL async_reset got out=%b cnt=%0d exp out=0 cnt=0", out, match_cnt);
        end
        @(posedge clk);
        #1;
        nrst = 1'b1;
        send_bit(1'b1, 1'b0, o, c);
        total++;
        if (o !== 1'b0) begin
            bad++; $display("FAIL reset_partial got=%b exp=0", o);
        end
        send_bit(1'b0, 1'b0, o, c);
        send_bit(1'b1, 1'b0, o, c);
        send_bit(1'b1, 1'b0, o, c);
        total++;
        if (o !== 1'b1 || c !== 3'd1) begin
            bad++; $display("FAIL reset_fresh got out=%b cnt=%0d exp out=1 cnt=1", o, c);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        nrst     = 1'b0;
        in_valid = 1'b0;
        in       = 1'b0;
        cfg_we   = 1'b0;
        cfg_pat  = '0;
        cfg_len  = '0;
        cfg_mode = 1'b0;
        cnt_clr  = 1'b0;
        test_reset();
        test_basic();
        test_overlap_modes();
        test_gaps();
        test_cfg_err();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
